// File: rtl/nrs_seq_gen.sv
// NB-IoT NRS QPSK bit generator: per slot, runs the Gold sequence for symbols l=5 and l=6
// and writes four (real, imag) sign-bit pairs into the NRS store.
module nrs_seq_gen #(
    parameter int unsigned NC       = 1600,
    parameter int unsigned M_OFFSET = 109,
    parameter int unsigned CID_W    = 9,
    parameter int unsigned NS_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CID_W-1:0] n_cell_id,
    input  logic [NS_W-1:0]  ns,
    output logic             nrs_r,
    output logic             nrs_i,
    output logic [1:0]       wr_addr,
    output logic             wr_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [30:0]      c_init_o
);

    localparam int unsigned SKIP_LEN = NC + 2 * M_OFFSET;
    localparam int unsigned K_W      = $clog2(SKIP_LEN + 1);

    localparam logic [K_W-1:0]   K_SKIP_LAST = K_W'(SKIP_LEN - 1);
    localparam logic [K_W-1:0]   K_GEN_LAST  = K_W'(3);
    localparam logic [K_W-1:0]   K_ONE       = K_W'(1);
    localparam logic [CID_W-1:0] CID_MAX     = CID_W'(503);
    localparam logic [NS_W-1:0]  NS_MAX      = NS_W'(19);

    typedef enum logic [2:0] {
        StIdle,
        StCinit,
        StLoad,
        StSkip,
        StGen,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;

    logic             r_l6;
    logic             w_l6_nxt;
    logic [CID_W-1:0] r_cid;
    logic [CID_W-1:0] w_cid_nxt;
    logic [NS_W-1:0]  r_ns;
    logic [NS_W-1:0]  w_ns_nxt;
    logic [30:0]      r_x1;
    logic [30:0]      w_x1_nxt;
    logic [30:0]      r_x2;
    logic [30:0]      w_x2_nxt;
    logic [K_W-1:0]   r_k;
    logic [K_W-1:0]   w_k_nxt;
    logic             r_even;
    logic             w_even_nxt;
    logic [30:0]      r_c_init;
    logic [30:0]      w_c_init_nxt;

    logic             r_nrs_r;
    logic             w_nrs_r_nxt;
    logic             r_nrs_i;
    logic             w_nrs_i_nxt;
    logic [1:0]       r_wr_addr;
    logic [1:0]       w_wr_addr_nxt;
    logic             r_wr_en;
    logic             w_wr_en_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_in_range;
    logic             w_c;
    logic [30:0]      w_x1_sh;
    logic [30:0]      w_x2_sh;
    logic [30:0]      w_sym;
    logic [30:0]      w_cid2;
    logic [30:0]      w_cinit;

    assign w_in_range = (n_cell_id <= CID_MAX) && (ns <= NS_MAX);

    // Bit 0 holds x(n); the new bit x(n+31) enters at the top.
    assign w_c     = r_x1[0] ^ r_x2[0];
    assign w_x1_sh = {r_x1[3] ^ r_x1[0], r_x1[30:1]};
    assign w_x2_sh = {r_x2[3] ^ r_x2[2] ^ r_x2[1] ^ r_x2[0], r_x2[30:1]};

    // (7*(ns+1) + l + 1) with l+1 = 6 or 7; all terms stay below 2^31 for valid inputs.
    assign w_sym   = 31'd7 * (31'(r_ns) + 31'd1) + (r_l6 ? 31'd7 : 31'd6);
    assign w_cid2  = (31'(r_cid) << 1) + 31'd1;
    assign w_cinit = ((w_sym * w_cid2) << 10) + w_cid2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_l6_nxt      = r_l6;
        w_cid_nxt     = r_cid;
        w_ns_nxt      = r_ns;
        w_x1_nxt      = r_x1;
        w_x2_nxt      = r_x2;
        w_k_nxt       = r_k;
        w_even_nxt    = r_even;
        w_c_init_nxt  = r_c_init;
        w_nrs_r_nxt   = r_nrs_r;
        w_nrs_i_nxt   = r_nrs_i;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_en_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (w_in_range) begin
                        w_state_nxt = StCinit;
                        w_l6_nxt    = 1'b0;
                        w_cid_nxt   = n_cell_id;
                        w_ns_nxt    = ns;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            StCinit: begin
                w_c_init_nxt = w_cinit;
                w_state_nxt  = StLoad;
            end
            StLoad: begin
                w_x1_nxt    = 31'd1;
                w_x2_nxt    = r_c_init;
                w_k_nxt     = '0;
                w_state_nxt = StSkip;
            end
            StSkip: begin
                w_x1_nxt = w_x1_sh;
                w_x2_nxt = w_x2_sh;
                if (r_k == K_SKIP_LAST) begin
                    w_k_nxt     = '0;
                    w_state_nxt = StGen;
                end else begin
                    w_k_nxt     = r_k + K_ONE;
                end
            end
            StGen: begin
                w_x1_nxt = w_x1_sh;
                w_x2_nxt = w_x2_sh;
                // Even cycles capture c(2m'), odd cycles complete the pair with c(2m'+1).
                if (!r_k[0]) begin
                    w_even_nxt    = w_c;
                end else begin
                    w_nrs_r_nxt   = r_even;
                    w_nrs_i_nxt   = w_c;
                    w_wr_addr_nxt = {r_l6, r_k[1]};
                    w_wr_en_nxt   = 1'b1;
                end
                if (r_k == K_GEN_LAST) begin
                    w_k_nxt = '0;
                    if (r_l6) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_l6_nxt    = 1'b1;
                        w_state_nxt = StCinit;
                    end
                end else begin
                    w_k_nxt = r_k + K_ONE;
                end
            end
            StDone: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_l6      <= 1'b0;
            r_cid     <= '0;
            r_ns      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_k       <= '0;
            r_even    <= 1'b0;
            r_c_init  <= '0;
            r_nrs_r   <= 1'b0;
            r_nrs_i   <= 1'b0;
            r_wr_addr <= 2'd0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_l6      <= w_l6_nxt;
            r_cid     <= w_cid_nxt;
            r_ns      <= w_ns_nxt;
            r_x1      <= w_x1_nxt;
            r_x2      <= w_x2_nxt;
            r_k       <= w_k_nxt;
            r_even    <= w_even_nxt;
            r_c_init  <= w_c_init_nxt;
            r_nrs_r   <= w_nrs_r_nxt;
            r_nrs_i   <= w_nrs_i_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign nrs_r    = r_nrs_r;
    assign nrs_i    = r_nrs_i;
    assign wr_addr  = r_wr_addr;
    assign wr_en    = r_wr_en;
    assign busy     = (r_state != StIdle);
    assign done     = r_done;
    assign err      = r_err;
    assign c_init_o = r_c_init;

endmodule
